// File: rtl/score_display.sv
// score_display
//   Shows two 5-bit player scores (0..31) as two decimal digits each on a
//   4-digit common-anode 7-segment display. P1 takes the left two digits
//   and P2 the right two. After a score changes, that player's digits blink
//   for BLINK_LEN clocks.
//
// Ports
//   clk       system clock
//   reset     asynchronous, active-high
//   score_p1  player-1 score, binary 0..31
//   score_p2  player-2 score, binary 0..31
//   seg       segments {g,f,e,d,c,b,a}, active-low, registered
//   an        digit enables, active-low, an[3] leftmost, registered
//   dp        decimal point, active-low, always off
module score_display #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLINK_TOGGLE = 12500000,
   parameter int BLINK_LEN    = 50000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] score_p1,
   input  logic [4:0] score_p2,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       dp
);

   localparam int RW = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
   localparam int PW = (BLINK_TOGGLE > 1) ? $clog2(BLINK_TOGGLE) : 1;
   localparam int BW = $clog2(BLINK_LEN + 1);

   localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] PHASE_LAST = PW'(BLINK_TOGGLE - 1);
   localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_LEN);

   logic [4:0]    s1, s2, p1, p2;
   logic [BW-1:0] blink1, blink2;
   logic [PW-1:0] phase_cnt;
   logic          phase;
   logic [RW-1:0] ref_cnt;
   logic [1:0]    idx;

   // Decimal split of a 0..31 value.
   function automatic logic [1:0] tens_of(input logic [4:0] v);
      if (v >= 5'd30)      return 2'd3;
      else if (v >= 5'd20) return 2'd2;
      else if (v >= 5'd10) return 2'd1;
      else                 return 2'd0;
   endfunction

   function automatic logic [3:0] ones_of(input logic [4:0] v);
      logic [4:0] r;
      case (tens_of(v))
         2'd3:    r = v - 5'd30;
         2'd2:    r = v - 5'd20;
         2'd1:    r = v - 5'd10;
         default: r = v;
      endcase
      return r[3:0];
   endfunction

   // Active-low {g,f,e,d,c,b,a}.
   function automatic logic [6:0] enc(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // Digit and enable for the current slot; BCD comes straight off the
   // sampled scores so input-to-seg latency is two clocks.
   logic [3:0] digit;
   logic [3:0] an_slot;
   logic       blank;

   always_comb begin
      digit   = 4'd0;
      an_slot = 4'b1111;
      blank   = 1'b0;
      case (idx)
         2'd0: begin
            digit   = ones_of(s2);
            an_slot = 4'b1110;
            blank   = (blink2 != '0) && phase;
         end
         2'd1: begin
            digit   = {2'b00, tens_of(s2)};
            an_slot = 4'b1101;
            blank   = (blink2 != '0) && phase;
         end
         2'd2: begin
            digit   = ones_of(s1);
            an_slot = 4'b1011;
            blank   = (blink1 != '0) && phase;
         end
         default: begin
            digit   = {2'b00, tens_of(s1)};
            an_slot = 4'b0111;
            blank   = (blink1 != '0) && phase;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1        <= '0;
         s2        <= '0;
         p1        <= '0;
         p2        <= '0;
         blink1    <= '0;
         blink2    <= '0;
         phase_cnt <= '0;
         phase     <= 1'b0;
         ref_cnt   <= '0;
         idx       <= 2'd0;
         seg       <= 7'b1111111;
         an        <= 4'b1111;
      end else begin
         s1 <= score_p1;
         s2 <= score_p2;
         p1 <= s1;
         p2 <= s2;

         // A change (re)starts the blink; otherwise count down to idle.
         if (s1 != p1)          blink1 <= BLINK_LOAD;
         else if (blink1 != '0) blink1 <= blink1 - 1'b1;
         if (s2 != p2)          blink2 <= BLINK_LOAD;
         else if (blink2 != '0) blink2 <= blink2 - 1'b1;

         if (phase_cnt == PHASE_LAST) begin
            phase_cnt <= '0;
            phase     <= ~phase;
         end else begin
            phase_cnt <= phase_cnt + 1'b1;
         end

         if (ref_cnt == REF_LAST) begin
            ref_cnt <= '0;
            idx     <= idx + 2'd1;
         end else begin
            ref_cnt <= ref_cnt + 1'b1;
         end

         seg <= blank ? 7'b1111111 : enc(digit);
         an  <= blank ? 4'b1111    : an_slot;
      end
   end

   assign dp = 1'b1;

endmodule

// File: tb/tb_score_display.sv
module tb_score_display;

   // BLINK_TOGGLE=6 instead of 8: with 8 the phase period (16) equals the
   // scan period (4 slots x 4), so phase=1 always lands on the P1 slots and
   // P2 could never be seen blanking. 6 makes the two beat against each other.
   localparam int REFRESH_DIV  = 4;
   localparam int BLINK_TOGGLE = 6;
   localparam int BLINK_LEN    = 64;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] score_p1, score_p2;
   logic [6:0] seg;
   logic [3:0] an;
   logic       dp;

   int n_cmp  = 0;
   int n_fail = 0;

   score_display #(
      .REFRESH_DIV (REFRESH_DIV),
      .BLINK_TOGGLE(BLINK_TOGGLE),
      .BLINK_LEN   (BLINK_LEN)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .score_p1(score_p1),
      .score_p2(score_p2),
      .seg     (seg),
      .an      (an),
      .dp      (dp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] p1;
      logic [4:0] p2;
      logic [6:0] s3;  // an=0111, P1 tens
      logic [6:0] s2;  // an=1011, P1 ones
      logic [6:0] s1;  // an=1101, P2 tens
      logic [6:0] s0;  // an=1110, P2 ones
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // One clock; outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_slot(input string nm, input logic [3:0] mask, input logic [6:0] exp);
      int waited;
      waited = 0;
      while (an != mask && waited < 20) begin
         tick();
         waited++;
      end
      if (an != mask) chk({nm, "_slot_timeout"}, int'(an), int'(mask));
      else            chk(nm, int'(seg), int'(exp));
   endtask

   task automatic count_win(input int n, output int p1c, output int p2c, output int blk);
      p1c = 0; p2c = 0; blk = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         case (an)
            4'b0111, 4'b1011: p1c++;
            4'b1110, 4'b1101: p2c++;
            4'b1111:          blk++;
            default:          ;
         endcase
      end
   endtask

   initial begin
      int p1c, p2c, blk;
      int seen_late, any_after;
      logic [3:0] exp_an;

      vecs[0] = '{5'd23, 5'd7,  7'b0100100, 7'b0110000, 7'b1000000, 7'b1111000};
      vecs[1] = '{5'd31, 5'd30, 7'b0110000, 7'b1111001, 7'b0110000, 7'b1000000};
      vecs[2] = '{5'd9,  5'd0,  7'b1000000, 7'b0010000, 7'b1000000, 7'b1000000};
      vecs[3] = '{5'd18, 5'd26, 7'b1111001, 7'b0000000, 7'b0100100, 7'b0000010};
      vecs[4] = '{5'd14, 5'd25, 7'b1111001, 7'b0011001, 7'b0100100, 7'b0010010};

      // Reset state and first scan after release
      reset = 1'b1; score_p1 = 5'd0; score_p2 = 5'd0;
      repeat (3) tick();
      chk("rst_an",  int'(an),  'hF);
      chk("rst_seg", int'(seg), 'h7F);
      chk("rst_dp",  int'(dp),  1);
      reset = 1'b0;
      for (int d = 1; d <= 16; d++) begin
         tick();
         exp_an = ~(4'b0001 << ((d - 1) / 4));
         chk($sformatf("scan_an_d%0d", d), int'(an), int'(exp_an));
         if (d % 4 == 1) chk($sformatf("scan_seg_d%0d", d), int'(seg), 'h40);
      end

      // Static digit patterns, checked after any blink has expired
      for (int v = 0; v < 5; v++) begin
         score_p1 = vecs[v].p1;
         score_p2 = vecs[v].p2;
         repeat (80) tick();
         check_slot($sformatf("v%0d_an3", v), 4'b0111, vecs[v].s3);
         check_slot($sformatf("v%0d_an2", v), 4'b1011, vecs[v].s2);
         check_slot($sformatf("v%0d_an1", v), 4'b1101, vecs[v].s1);
         check_slot($sformatf("v%0d_an0", v), 4'b1110, vecs[v].s0);
         chk($sformatf("v%0d_dp", v), int'(dp), 1);
      end

      // P2 0->1: only P2 blinks, then "01" steady
      score_p1 = 5'd5; score_p2 = 5'd0;
      repeat (80) tick();
      score_p2 = 5'd1;
      repeat (2) tick();
      count_win(64, p1c, p2c, blk);
      chk("p2blink_p1_slots", p1c, 32);
      chk("p2blink_blank_seen", int'(blk > 0), 1);
      chk("p2blink_p2_short", int'(p2c < 32), 1);
      repeat (10) tick();
      count_win(64, p1c, p2c, blk);
      chk("p2after_blank", blk, 0);
      chk("p2after_p2_slots", p2c, 32);
      check_slot("p2after_ones", 4'b1110, 7'b1111001);
      check_slot("p2after_tens", 4'b1101, 7'b1000000);

      // Both change together -> both blink, both finish
      score_p1 = 5'd31; score_p2 = 5'd30;
      repeat (2) tick();
      count_win(64, p1c, p2c, blk);
      chk("both_p1_short", int'(p1c < 32), 1);
      chk("both_p2_short", int'(p2c < 32), 1);
      count_win(64, p1c, p2c, blk);
      chk("both_after_blank", blk, 0);

      // P1 change, then change again 30 clk later: blink extends to +30+64
      score_p1 = 5'd20;
      seen_late = 0; any_after = 0;
      for (int d = 1; d <= 160; d++) begin
         tick();
         if (an == 4'b1111) begin
            if (d >= 70 && d <= 96) seen_late = 1;
            if (d >= 97)            any_after = 1;
         end
         if (d == 30) score_p1 = 5'd21;
      end
      chk("reload_blank_late", seen_late, 1);
      chk("reload_blank_after", any_after, 0);

      // Reset mid-scan with blink active
      score_p1 = 5'd7;
      repeat (10) tick();
      score_p1 = 5'd0; score_p2 = 5'd0;
      reset = 1'b1;
      #1;
      chk("midrst_an",  int'(an),  'hF);
      chk("midrst_seg", int'(seg), 'h7F);
      repeat (3) tick();
      chk("midrst_hold_an", int'(an), 'hF);
      reset = 1'b0;
      tick();
      chk("midrst_rel_an",  int'(an),  'hE);
      chk("midrst_rel_seg", int'(seg), 'h40);
      count_win(64, p1c, p2c, blk);
      chk("midrst_zero_blank", blk, 0);

      // Nonzero score present at reset release counts as a change
      reset = 1'b1;
      repeat (2) tick();
      score_p1 = 5'd12; score_p2 = 5'd0;
      reset = 1'b0;
      repeat (2) tick();
      count_win(64, p1c, p2c, blk);
      chk("rel_nz_p1_short", int'(p1c < 32), 1);
      chk("rel_nz_p2_slots", p2c, 32);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
